// File: rtl/image_select_ctrl.sv
// Button-driven image selector: sync + debounce per button, wrap/saturate index, clean commit.
// Optional `IMG_SEL_FRAME_SYNC_EN defers the commit to the vsync falling edge.
module image_select_ctrl #(
  parameter int NUM_IMAGES      = 4,
  parameter int SEL_W           = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DB_CNT_W        = 19,
  parameter int WRAP            = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             left_button,
  input  logic             right_button,
  input  logic             vsync,
  output logic [SEL_W-1:0] select,
  output logic             select_pending,
  output logic             step_left,
  output logic             step_right
);

  localparam logic [SEL_W-1:0]    MAX_IDX = SEL_W'(NUM_IMAGES - 1);
  localparam logic [DB_CNT_W-1:0] CNT_MAX = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       raw, stable, stable_q, press;
  logic             left_only, right_only;
  logic [SEL_W-1:0] target;

  assign raw = {right_button, left_button};

  // bit 0 = left, bit 1 = right
  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic [1:0]          sync;
    logic [DB_CNT_W-1:0] cnt;
    logic                stb;

    always_ff @(posedge clk) begin
      if (reset) begin
        sync <= '0;
        cnt  <= '0;
        stb  <= 1'b0;
      end else begin
        sync <= {sync[0], raw[b]};
        if (sync[1] == stb) begin
          cnt <= '0;
        end else if (cnt == CNT_MAX) begin
          stb <= sync[1];
          cnt <= '0;
        end else begin
          cnt <= cnt + DB_CNT_W'(1);
        end
      end
    end

    assign stable[b] = stb;
  end

  assign press      = stable & ~stable_q;
  assign left_only  = press[0] & ~press[1];
  assign right_only = press[1] & ~press[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      stable_q   <= '0;
      target     <= '0;
      step_left  <= 1'b0;
      step_right <= 1'b0;
    end else begin
      stable_q   <= stable;
      step_left  <= left_only;
      step_right <= right_only;
      // Compare against the end points rather than using modulo so non-power-of-two counts stay in range
      if (left_only) begin
        if (target == '0) target <= (WRAP != 0) ? MAX_IDX : '0;
        else              target <= target - SEL_W'(1);
      end else if (right_only) begin
        if (target == MAX_IDX) target <= (WRAP != 0) ? '0 : MAX_IDX;
        else                   target <= target + SEL_W'(1);
      end
    end
  end

`ifdef IMG_SEL_FRAME_SYNC_EN
  logic vsync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q <= 1'b1;
      select  <= '0;
    end else begin
      vsync_q <= vsync;
      if (vsync_q & ~vsync) select <= target;
    end
  end
`else
  logic unused_vsync;
  assign unused_vsync = vsync;

  always_ff @(posedge clk) begin
    if (reset) select <= '0;
    else       select <= target;
  end
`endif

  assign select_pending = (target != select);

endmodule

// File: tb/tb_image_select_ctrl.sv
// Bench for image_select_ctrl: WRAP=1 and WRAP=0 instances share stimulus, checked per cycle against a window-based model.
module tb_image_select_ctrl;
  localparam int N  = 3;
  localparam int SW = 2;
  localparam int D  = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic reset = 1'b1, left_button = 1'b0, right_button = 1'b0, vsync = 1'b1;
  logic [SW-1:0] sel_o [2];
  logic pend_o [2], sl_o [2], sr_o [2];

  always #5 clk = ~clk;

  image_select_ctrl #(.NUM_IMAGES(N), .SEL_W(SW), .DEBOUNCE_CYCLES(D), .DB_CNT_W(CW), .WRAP(1)) u_w1 (
    .clk(clk), .reset(reset), .left_button(left_button), .right_button(right_button), .vsync(vsync),
    .select(sel_o[0]), .select_pending(pend_o[0]), .step_left(sl_o[0]), .step_right(sr_o[0]));

  image_select_ctrl #(.NUM_IMAGES(N), .SEL_W(SW), .DEBOUNCE_CYCLES(D), .DB_CNT_W(CW), .WRAP(0)) u_w0 (
    .clk(clk), .reset(reset), .left_button(left_button), .right_button(right_button), .vsync(vsync),
    .select(sel_o[1]), .select_pending(pend_o[1]), .step_left(sl_o[1]), .step_right(sr_o[1]));

  int errors = 0, checks = 0;

  // Reference model: index 0 models WRAP=1, index 1 models WRAP=0
  int m_tgt [2], m_sel [2], m_sl [2], m_sr [2];
  int m_stb [2], m_rise [2];
  int m_vq;
  int hq0 [$], hq1 [$];
  int cnt_sl [2], cnt_sr [2];

  typedef struct {
    bit l;
    bit r;
    int sel_w1;
    int sel_w0;
    int n_sl;
    int n_sr;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string nm, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, want, $time);
    end
  endtask

  // The level is accepted once the synchronised input has disagreed with it for D consecutive edges
  function automatic bit run_done(input int q [$], input int st);
    for (int i = 2; i <= D + 1; i++)
      if (q[q.size() - i] == st) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    int pl, pr, t;
    bit flip;
    if (reset) begin
      hq0.delete();
      hq1.delete();
      for (int i = 0; i < D + 2; i++) begin
        hq0.push_back(0);
        hq1.push_back(0);
      end
      for (int b = 0; b < 2; b++) begin
        m_stb[b] = 0; m_rise[b] = 0;
        m_tgt[b] = 0; m_sel[b] = 0; m_sl[b] = 0; m_sr[b] = 0;
      end
      m_vq = 1;
      return;
    end
    pl = m_rise[0];
    pr = m_rise[1];
    for (int b = 0; b < 2; b++) begin
      if (b == 0) flip = run_done(hq0, m_stb[0]);
      else        flip = run_done(hq1, m_stb[1]);
      m_rise[b] = (flip && m_stb[b] == 0) ? 1 : 0;
      if (flip) m_stb[b] = 1 - m_stb[b];
    end
    hq0.push_back(int'(left_button));
    hq1.push_back(int'(right_button));
    if (hq0.size() > D + 4) void'(hq0.pop_front());
    if (hq1.size() > D + 4) void'(hq1.pop_front());
    for (int d = 0; d < 2; d++) begin
      t = m_tgt[d];
`ifdef IMG_SEL_FRAME_SYNC_EN
      if (m_vq == 1 && vsync == 1'b0) m_sel[d] = t;
`else
      m_sel[d] = t;
`endif
      m_sl[d] = (pl == 1 && pr == 0) ? 1 : 0;
      m_sr[d] = (pr == 1 && pl == 0) ? 1 : 0;
      if (m_sl[d] == 1) m_tgt[d] = (d == 0) ? (t + N - 1) % N : ((t > 0) ? t - 1 : 0);
      if (m_sr[d] == 1) m_tgt[d] = (d == 0) ? (t + 1) % N : ((t < N - 1) ? t + 1 : t);
    end
    m_vq = int'(vsync);
  endtask

  task automatic tick();
    string w;
    model_step();
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      w = (d == 0) ? "w1" : "w0";
      chk({"select_", w},  int'(sel_o[d]),  m_sel[d]);
      chk({"pending_", w}, int'(pend_o[d]), (m_tgt[d] != m_sel[d]) ? 1 : 0);
      chk({"step_l_", w},  int'(sl_o[d]),   m_sl[d]);
      chk({"step_r_", w},  int'(sr_o[d]),   m_sr[d]);
      cnt_sl[d] += int'(sl_o[d]);
      cnt_sr[d] += int'(sr_o[d]);
    end
  endtask

  task automatic clr_counts();
    for (int d = 0; d < 2; d++) begin
      cnt_sl[d] = 0;
      cnt_sr[d] = 0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; left_button = 1'b0; right_button = 1'b0; vsync = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  // Hold a press long enough to debounce, release, then give one vsync fall to commit
  task automatic phase(input bit l, input bit r);
    clr_counts();
    left_button = l; right_button = r;
    repeat (10) tick();
    left_button = 1'b0; right_button = 1'b0;
    repeat (10) tick();
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    tick();
  endtask

  initial begin
    tbl[0] = '{l: 0, r: 1, sel_w1: 1, sel_w0: 1, n_sl: 0, n_sr: 1};
    tbl[1] = '{l: 0, r: 1, sel_w1: 2, sel_w0: 2, n_sl: 0, n_sr: 1};
    tbl[2] = '{l: 0, r: 1, sel_w1: 0, sel_w0: 2, n_sl: 0, n_sr: 1};
    tbl[3] = '{l: 1, r: 0, sel_w1: 2, sel_w0: 1, n_sl: 1, n_sr: 0};
    tbl[4] = '{l: 1, r: 0, sel_w1: 1, sel_w0: 0, n_sl: 1, n_sr: 0};
    tbl[5] = '{l: 1, r: 0, sel_w1: 0, sel_w0: 0, n_sl: 1, n_sr: 0};
    tbl[6] = '{l: 1, r: 0, sel_w1: 2, sel_w0: 0, n_sl: 1, n_sr: 0};
    tbl[7] = '{l: 1, r: 1, sel_w1: 2, sel_w0: 0, n_sl: 0, n_sr: 0};

    // Reset state
    do_reset();
    for (int d = 0; d < 2; d++) begin
      chk("rst_select",  int'(sel_o[d]),  0);
      chk("rst_pending", int'(pend_o[d]), 0);
      chk("rst_step_l",  int'(sl_o[d]),   0);
      chk("rst_step_r",  int'(sr_o[d]),   0);
    end

    // Clean right press from edge 0: step at edge 6, select at edge 7
    right_button = 1'b1;
    for (int e = 0; e <= 8; e++) begin
      tick();
      chk("first_step_r", int'(sr_o[0]), (e == 6) ? 1 : 0);
`ifdef IMG_SEL_FRAME_SYNC_EN
      chk("first_select", int'(sel_o[0]), 0);
`else
      chk("first_select", int'(sel_o[0]), (e >= 7) ? 1 : 0);
`endif
    end
    right_button = 1'b0;
    repeat (8) tick();

    // Bounces shorter than the debounce window are ignored
    do_reset();
    clr_counts();
    for (int k = 0; k < 5; k++) begin
      right_button = 1'b1;
      repeat (3) tick();
      right_button = 1'b0;
      repeat (3) tick();
    end
    repeat (8) tick();
    vsync = 1'b0; tick(); vsync = 1'b1; tick();
    for (int d = 0; d < 2; d++) begin
      chk("bounce_steps", cnt_sl[d] + cnt_sr[d], 0);
      chk("bounce_select", int'(sel_o[d]), 0);
    end

    // Table of press phases: wrap/saturate behaviour and simultaneous-press cancel
    for (int i = 0; i < 8; i++) begin
      phase(tbl[i].l, tbl[i].r);
      chk("tbl_select_w1", int'(sel_o[0]), tbl[i].sel_w1);
      chk("tbl_select_w0", int'(sel_o[1]), tbl[i].sel_w0);
      for (int d = 0; d < 2; d++) begin
        chk("tbl_n_step_l", cnt_sl[d], tbl[i].n_sl);
        chk("tbl_n_step_r", cnt_sr[d], tbl[i].n_sr);
        chk("tbl_pending",  int'(pend_o[d]), 0);
      end
    end

    // Two right presses within one frame, then a vsync fall
    do_reset();
    for (int k = 0; k < 2; k++) begin
      right_button = 1'b1;
      repeat (10) tick();
      right_button = 1'b0;
      repeat (10) tick();
    end
`ifdef IMG_SEL_FRAME_SYNC_EN
    chk("frame_pending_before", int'(pend_o[0]), 1);
    chk("frame_select_before",  int'(sel_o[0]),  0);
`else
    chk("frame_pending_before", int'(pend_o[0]), 0);
    chk("frame_select_before",  int'(sel_o[0]),  2);
`endif
    vsync = 1'b0;
    tick();
    chk("frame_select_after",  int'(sel_o[0]),  2);
    chk("frame_pending_after", int'(pend_o[0]), 0);
    vsync = 1'b1;
    tick();

    // One-cycle reset mid-debounce with select=2; the held button needs a fresh debounce
    right_button = 1'b1;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk("midrst_select", int'(sel_o[d]), 0);
      chk("midrst_step_r", int'(sr_o[d]),  0);
    end
    for (int j = 1; j <= D + 3; j++) begin
      tick();
      chk("midrst_redebounce", int'(sr_o[0]), (j == D + 3) ? 1 : 0);
    end
    right_button = 1'b0;
    repeat (8) tick();

    // Randomised levels, vsync and occasional reset, checked cycle by cycle
    for (int i = 0; i < 60; i++) begin
      left_button  = 1'($urandom_range(0, 1));
      right_button = 1'($urandom_range(0, 1));
      vsync        = ($urandom_range(0, 3) != 0);
      reset        = ($urandom_range(0, 39) == 0);
      repeat ($urandom_range(1, 10)) tick();
    end
    reset = 1'b0; left_button = 1'b0; right_button = 1'b0; vsync = 1'b1;
    repeat (10) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
